// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Register front end for a UART receiver: buffers received bytes in a
// FIFO, exposes data/status/baud/control registers over a simple strobe
// bus and raises a level interrupt on overrun or on a fill threshold.
//
// Ports
//   i_Clk          clock, rising edge
//   i_Rst_n        asynchronous active-low reset
//   i_Wr / i_Rd    one-cycle register write / read strobes
//   i_Addr         0 DATA, 1 STATUS, 2 BAUD, 3 CTRL
//   i_WrData       write data
//   o_RdData       read data, valid the cycle after i_Rd, held until next read
//   o_ClksPerBit   baud divisor driven to the receiver
//   i_RxDataValid  receiver byte-complete pulse
//   i_RxData       received byte, qualified by i_RxDataValid
//   o_Irq          registered level interrupt
module uart_rx_ctrl #(
    parameter int          FIFO_DEPTH       = 8,
    parameter logic [15:0] RST_CLKS_PER_BIT = 16'd868
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Wr,
    input  logic        i_Rd,
    input  logic [1:0]  i_Addr,
    input  logic [15:0] i_WrData,
    output logic [15:0] o_RdData,
    output logic [15:0] o_ClksPerBit,
    input  logic        i_RxDataValid,
    input  logic [7:0]  i_RxData,
    output logic        o_Irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_BAUD   = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    typedef enum logic {S_IDLE, S_POP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overrun;
    logic          rx_en;
    logic          irq_en;
    logic [4:0]    threshold;
    logic [15:0]   clks_per_bit;
    state_t        state;
    logic          pop_pend;

    logic          empty;
    logic          full;
    logic          pop_now;
    logic          flush;
    logic          push_ok;
    logic          ovr_set;
    logic          ovr_clr;
    logic [4:0]    count_ext;
    logic [15:0]   rd_mux;
    logic          irq_next;

    always_comb begin
        empty     = (count == '0);
        full      = (count == CW'(FIFO_DEPTH));
        count_ext = 5'(count);
        // The pop decided at read time is committed here; re-checking
        // empty guards against a flush landing between read and commit.
        pop_now   = (state == S_POP) && pop_pend && !empty;
        flush     = i_Wr && (i_Addr == A_CTRL) && i_WrData[2];
        // A pop committing this cycle frees a slot, so a full FIFO can
        // still accept a byte. A flush in the same cycle drops the byte
        // without flagging overrun.
        push_ok   = i_RxDataValid && rx_en && !flush && (!full || pop_now);
        ovr_set   = i_RxDataValid && rx_en && !flush && full && !pop_now;
        ovr_clr   = i_Wr && (i_Addr == A_STATUS) && i_WrData[2];
        irq_next  = irq_en && (overrun ||
                               ((threshold != 5'd0) && (count_ext >= threshold)));
    end

    // Read mux reflects pre-write register values, so a simultaneous
    // write and read returns the old contents.
    always_comb begin
        rd_mux = 16'h0000;
        case (i_Addr)
            A_DATA: begin
                // A DATA read during POP is too early to see the next
                // head and returns zero without popping.
                if (state == S_IDLE && !empty)
                    rd_mux = {8'h00, mem[rd_ptr]};
            end
            A_STATUS: rd_mux = {7'b0, count_ext, 1'b0, overrun, full, !empty};
            A_BAUD:   rd_mux = clks_per_bit;
            A_CTRL:   rd_mux = {7'b0, threshold, 2'b00, irq_en, rx_en};
            default:  rd_mux = 16'h0000;
        endcase
    end

    // FIFO storage carries no reset; validity is tracked by count/pointers.
    always_ff @(posedge i_Clk) begin
        if (push_ok)
            mem[wr_ptr] <= i_RxData;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overrun      <= 1'b0;
            rx_en        <= 1'b0;
            irq_en       <= 1'b0;
            threshold    <= 5'd0;
            clks_per_bit <= RST_CLKS_PER_BIT;
            state        <= S_IDLE;
            pop_pend     <= 1'b0;
            o_RdData     <= 16'h0000;
            o_Irq        <= 1'b0;
        end else begin
            o_Irq <= irq_next;

            if (i_Rd)
                o_RdData <= rd_mux;

            case (state)
                S_IDLE: begin
                    if (i_Rd && i_Addr == A_DATA) begin
                        state    <= S_POP;
                        pop_pend <= !empty;
                    end
                end
                S_POP: begin
                    state    <= S_IDLE;
                    pop_pend <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    pop_pend <= 1'b0;
                end
            endcase

            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                pop_pend <= 1'b0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop_now)
                    rd_ptr <= rd_ptr + PW'(1);
                case ({push_ok, pop_now})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            // Set has priority over a clearing STATUS write.
            if (ovr_set)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            if (i_Wr) begin
                case (i_Addr)
                    A_BAUD: begin
                        if (i_WrData >= 16'd4)
                            clks_per_bit <= i_WrData;
                    end
                    A_CTRL: begin
                        rx_en     <= i_WrData[0];
                        irq_en    <= i_WrData[1];
                        threshold <= i_WrData[8:4];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_ClksPerBit = clks_per_bit;

endmodule
